// File: rtl/uart_frame_loader_if.sv
// Byte-stream input, raster strobes and loader status bundled between
// the UART receiver / VGA timing side and the frame loader.
interface uart_frame_loader_if #(
  parameter int unsigned PIX_W = 8
);
  logic [7:0]       rx_data;
  logic             rx_flag;
  logic             pix_en;
  logic             area;
  logic             frame_start;
  logic [PIX_W-1:0] dout;
  logic             frame_done;
  logic             err_timeout;
  logic             busy;

  modport master (
    output rx_data, rx_flag, pix_en, area, frame_start,
    input  dout, frame_done, err_timeout, busy
  );

  modport slave (
    input  rx_data, rx_flag, pix_en, area, frame_start,
    output dout, frame_done, err_timeout, busy
  );
endinterface

// File: rtl/uart_frame_loader.sv
// Double-buffered frame loader: parses sync + IMG_W*IMG_H pixel bytes into
// the back bank and swaps banks only at a displayed frame boundary.
module uart_frame_loader #(
  parameter int unsigned IMG_W      = 100,
  parameter int unsigned IMG_H      = 100,
  parameter int unsigned PIX_W      = 8,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int unsigned TIMEOUT    = 50_000_000,
  parameter int unsigned DOUBLE_BUF = 1
) (
  input logic              sclk,
  input logic              rst_n,
  uart_frame_loader_if.slave bus
);

  localparam int unsigned N     = IMG_W * IMG_H;
  localparam int unsigned AW    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned NBANK = (DOUBLE_BUF != 0) ? 2 : 1;
  localparam int unsigned TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
  localparam logic [TW-1:0] IDLE_MAX  = TW'(TIMEOUT - 1);
  localparam logic          DBUF      = (DOUBLE_BUF != 0);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t           state;
  logic             front;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;
  logic [TW-1:0]    idle_cnt;
  logic [PIX_W-1:0] dout_q;
  logic             frame_done_q;
  logic             err_timeout_q;
  logic             busy_q;

  logic [PIX_W-1:0] mem [NBANK][N];

  logic             back_c;
  logic             wr_en_c;
  logic             swap_c;
  logic             rd_bank_c;
  logic [AW-1:0]    rd_idx_c;

  assign bus.dout        = dout_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.busy        = busy_q;

  // Bank selection, write enable, swap decision and read address.
  // A frame_start coinciding with frame_done is deliberately not a swap.
  always_comb begin
    back_c    = DBUF ? ~front : front;
    wr_en_c   = (state == S_LOAD) && bus.rx_flag;
    swap_c    = DBUF && (state == S_DONE) && bus.frame_start && !frame_done_q;
    rd_bank_c = front ^ swap_c;
    rd_idx_c  = bus.frame_start ? '0 : rd_addr;
  end

  // Frame memory write port; contents are not reset.
  always_ff @(posedge sclk) begin
    if (wr_en_c) begin
      mem[back_c][wr_addr] <= bus.rx_data[PIX_W-1:0];
    end
  end

  // Write FSM: sync hunt, pixel load with idle timeout, wait for swap.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      front         <= 1'b0;
      wr_addr       <= '0;
      idle_cnt      <= '0;
      frame_done_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      frame_done_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.rx_flag && (bus.rx_data == SYNC_BYTE)) begin
            state    <= S_LOAD;
            wr_addr  <= '0;
            idle_cnt <= '0;
            busy_q   <= 1'b1;
          end
        end
        S_LOAD: begin
          if (bus.rx_flag) begin
            idle_cnt <= '0;
            if (wr_addr == LAST_ADDR) begin
              state        <= S_DONE;
              wr_addr      <= '0;
              frame_done_q <= 1'b1;
            end else begin
              wr_addr <= wr_addr + AW'(1);
            end
          end else if (idle_cnt == IDLE_MAX) begin
            state         <= S_IDLE;
            err_timeout_q <= 1'b1;
            busy_q        <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end
        S_DONE: begin
          if (!DBUF) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end else if (swap_c) begin
            front  <= ~front;
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Raster read path: saturating address, black outside the image window.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
      dout_q  <= '0;
    end else begin
      if (bus.frame_start) begin
        rd_addr <= '0;
      end else if (bus.pix_en && bus.area && (rd_addr != LAST_ADDR)) begin
        rd_addr <= rd_addr + AW'(1);
      end
      if (bus.pix_en) begin
        dout_q <= bus.area ? mem[rd_bank_c][rd_idx_c] : '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Scoreboard bench for uart_frame_loader with a 4x2 image, double buffered.
module tb_uart_frame_loader;

  localparam int unsigned NPIX = 8;
  localparam logic [7:0]  SYNC = 8'hA5;

  typedef logic [7:0] frame_t [NPIX];

  logic sclk  = 1'b0;
  logic rst_n = 1'b0;
  always #5 sclk = ~sclk;

  uart_frame_loader_if #(.PIX_W(8)) bus();

  uart_frame_loader #(
    .IMG_W(4), .IMG_H(2), .PIX_W(8), .SYNC_BYTE(8'hA5),
    .TIMEOUT(64), .DOUBLE_BUF(1)
  ) dut (
    .sclk  (sclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp   = 0;
  int n_bad   = 0;
  int fd_cnt  = 0;
  int err_cnt = 0;
  logic [7:0] exp_q [$];
  logic pv = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Remember whether the last edge was a pixel strobe.
  always @(posedge sclk) pv <= bus.pix_en;

  // Count status pulses and compare each strobed pixel against the scoreboard.
  always @(negedge sclk) begin
    if (rst_n) begin
      if (bus.frame_done)  fd_cnt++;
      if (bus.err_timeout) err_cnt++;
    end
    if (pv) begin
      if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else                   check("dout", 32'(bus.dout), 32'(exp_q.pop_front()));
    end
  end

  function automatic frame_t mk(input logic [7:0] base);
    frame_t f;
    for (int i = 0; i < NPIX; i++) f[i] = base + 8'(i);
    return f;
  endfunction

  task automatic cyc();
    @(posedge sclk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_flag = 1'b1;
    cyc();
    bus.rx_flag = 1'b0;
    cyc();
  endtask

  task automatic load(input frame_t f);
    send(SYNC);
    for (int i = 0; i < NPIX; i++) send(f[i]);
  endtask

  task automatic pix(input logic a, input logic [7:0] e);
    bus.pix_en = 1'b1;
    bus.area   = a;
    exp_q.push_back(e);
    cyc();
    bus.pix_en = 1'b0;
    bus.area   = 1'b0;
  endtask

  task automatic read_frame(input frame_t f);
    for (int i = 0; i < NPIX; i++) pix(1'b1, f[i]);
    cyc();
  endtask

  task automatic show(input frame_t f);
    bus.frame_start = 1'b1;
    cyc();
    bus.frame_start = 1'b0;
    read_frame(f);
  endtask

  initial begin
    frame_t f;
    int fd0, er0;
    bus.rx_data     = 8'h00;
    bus.rx_flag     = 1'b0;
    bus.pix_en      = 1'b0;
    bus.area        = 1'b0;
    bus.frame_start = 1'b0;

    #12;
    check("rst_dout",  32'(bus.dout), 32'd0);
    check("rst_fdone", 32'(bus.frame_done), 32'd0);
    check("rst_err",   32'(bus.err_timeout), 32'd0);
    check("rst_busy",  32'(bus.busy), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // 1: normal load, display, saturation
    fd0 = fd_cnt;
    send(SYNC);
    check("t1_busy_load", 32'(bus.busy), 32'd1);
    for (int i = 0; i < NPIX; i++) send(8'(i + 1));
    check("t1_fdone", 32'(fd_cnt - fd0), 32'd1);
    check("t1_busy_done", 32'(bus.busy), 32'd1);
    show(mk(8'h01));
    check("t1_busy_idle", 32'(bus.busy), 32'd0);
    pix(1'b1, 8'h08);
    pix(1'b1, 8'h08);
    cyc();

    // 2: garbage before sync, sync value inside load is data
    fd0 = fd_cnt;
    send(8'h00);
    send(8'hFF);
    check("t2_no_busy", 32'(bus.busy), 32'd0);
    f = mk(8'h10);
    f[2] = SYNC;
    load(f);
    check("t2_fdone", 32'(fd_cnt - fd0), 32'd1);
    show(f);

    // 3: no tearing while the back bank loads; bytes in DONE ignored
    load(mk(8'h01));
    show(mk(8'h01));
    fd0 = fd_cnt;
    send(SYNC);
    for (int i = 0; i < 4; i++) send(8'h20 + 8'(i));
    show(mk(8'h01));
    for (int i = 4; i < NPIX; i++) send(8'h20 + 8'(i));
    check("t3_fdone", 32'(fd_cnt - fd0), 32'd1);
    read_frame('{8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08});
    send(SYNC);
    send(8'h30);
    send(8'h31);
    check("t3_done_ignore", 32'(fd_cnt - fd0), 32'd1);
    show(mk(8'h20));
    check("t3_busy_idle", 32'(bus.busy), 32'd0);

    // 4: timeout mid-load, then recovery
    er0 = err_cnt;
    send(SYNC);
    send(8'h01);
    send(8'h02);
    idle(55);
    check("t4_no_early_err", 32'(err_cnt - er0), 32'd0);
    check("t4_busy_wait", 32'(bus.busy), 32'd1);
    idle(20);
    check("t4_err_once", 32'(err_cnt - er0), 32'd1);
    check("t4_busy_fall", 32'(bus.busy), 32'd0);
    fd0 = fd_cnt;
    load(mk(8'h40));
    check("t4_fdone", 32'(fd_cnt - fd0), 32'd1);
    show(mk(8'h40));

    // 5: black border, and frame_start colliding with frame_done
    pix(1'b0, 8'h00);
    pix(1'b1, 8'h47);
    pix(1'b0, 8'h00);
    cyc();
    fd0 = fd_cnt;
    send(SYNC);
    for (int i = 0; i < NPIX - 1; i++) send(8'h50 + 8'(i));
    bus.rx_data = 8'h57;
    bus.rx_flag = 1'b1;
    cyc();
    bus.rx_flag     = 1'b0;
    bus.frame_start = 1'b1;
    cyc();
    bus.frame_start = 1'b0;
    cyc();
    check("t5_fdone", 32'(fd_cnt - fd0), 32'd1);
    check("t5_no_swap_busy", 32'(bus.busy), 32'd1);
    read_frame(mk(8'h40));
    show(mk(8'h50));
    check("t5_busy_idle", 32'(bus.busy), 32'd0);

    // 6: reset in the middle of a load
    send(SYNC);
    send(8'h60);
    send(8'h61);
    send(8'h62);
    rst_n = 1'b0;
    #2;
    check("t6_dout",  32'(bus.dout), 32'd0);
    check("t6_fdone", 32'(bus.frame_done), 32'd0);
    check("t6_err",   32'(bus.err_timeout), 32'd0);
    check("t6_busy",  32'(bus.busy), 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    fd0 = fd_cnt;
    load(mk(8'h70));
    check("t6_fdone", 32'(fd_cnt - fd0), 32'd1);
    show(mk(8'h70));

    idle(2);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
